// File: rtl/mem_wait_model_if.sv
// Request/response bus between a processor (master) and the wait-state memory model (slave).
// The processor holds mem_read/mem_write until the one-cycle mem_resp pulse.
interface mem_wait_model_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata, mem_err
  );
endinterface

// File: rtl/mem_wait_model.sv
// Fixed-latency word memory with byte-lane writes, address-range faulting and a
// one-cycle completion pulse LATENCY cycles after a request is accepted.
module mem_wait_model #(
  parameter int unsigned LATENCY     = 3,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  mem_wait_model_if.slave bus
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_reg;
  logic [3:0]      count_reg;
  logic [AW-1:0]   idx_reg;
  logic [31:0]     wdata_reg;
  logic [3:0]      be_reg;
  logic            write_reg;
  logic            fault_reg;
  logic            resp_reg;
  logic            err_reg;
  logic [31:0]     rdata_reg;

  logic [31:0]     storage [DEPTH_WORDS];

  logic            req;
  logic [31:0]     in_off;
  logic            in_fault;
  logic [AW-1:0]   in_idx;
  logic [AW-1:0]   cur_idx;
  logic            cur_read;
  logic            cur_fault;
  logic            to_resp;
  logic            commit;
  logic [3:0]      lane_we;

  assign req      = bus.mem_read | bus.mem_write;
  assign in_off   = bus.mem_address - BASE_ADDR;
  assign in_fault = (bus.mem_read & bus.mem_write) |
                    (bus.mem_address < BASE_ADDR) |
                    ({1'b0, in_off} >= SPAN);
  assign in_idx   = in_off[AW+1:2];

  // In IDLE the live inputs feed the read port so LATENCY=1 can respond next cycle.
  always_comb begin
    if (state_reg == IDLE) begin
      cur_idx   = in_idx;
      cur_read  = ~bus.mem_write;
      cur_fault = in_fault;
    end else begin
      cur_idx   = idx_reg;
      cur_read  = ~write_reg;
      cur_fault = fault_reg;
    end
    to_resp = ((state_reg == IDLE) && req && (LATENCY == 1)) ||
              ((state_reg == WAIT) && (count_reg == 4'd1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
      resp_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      resp_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            idx_reg   <= in_idx;
            wdata_reg <= bus.mem_wdata;
            be_reg    <= bus.mem_byte_enable;
            write_reg <= bus.mem_write & ~bus.mem_read;
            fault_reg <= in_fault;
            if (LATENCY == 1) begin
              state_reg <= RESP;
              resp_reg  <= 1'b1;
              err_reg   <= in_fault;
            end else begin
              state_reg <= WAIT;
              count_reg <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          count_reg <= count_reg - 4'd1;
          if (count_reg == 4'd1) begin
            state_reg <= RESP;
            resp_reg  <= 1'b1;
            err_reg   <= fault_reg;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Writes land on the edge that closes RESP; a reset on that edge drops them.
  assign commit = rst & (state_reg == RESP) & write_reg & ~fault_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = commit & be_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) storage[idx_reg][8*b +: 8] <= wdata_reg[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_reg <= '0;
    end else if (to_resp) begin
      if (cur_fault)     rdata_reg <= '0;
      else if (cur_read) rdata_reg <= storage[cur_idx];
    end
  end

  assign bus.mem_resp  = resp_reg;
  assign bus.mem_err   = err_reg;
  assign bus.mem_rdata = rdata_reg;

endmodule
